icache_dm: RTL and testbench

- Direct-mapped instruction cache that acts as the responder on the fetch-to-icache request interface.
- Accepts one 16-byte line request at a time and returns 128 bits of line data.
- Refills misses through a single-beat 128-bit memory read port.
- Invalidates the whole array on reset and on each flush request. Sits between the fetch stage and the instruction memory/bus bridge.

---
 rtl/icache_dm.sv | 169 ++++++++++++++++
 tb/tb_icache_dm.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : icache_dm
//  Purpose  : Direct-mapped instruction cache, 16-byte lines, 128-bit line
//             responses, single-beat refill through a 128-bit memory port.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_dm #(
  parameter int INDEX_W = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_rd_i,
  input  logic         req_flush_i,
  input  logic         req_invalidate_i,
  input  logic [31:0]  req_pc_i,
  input  logic [1:0]   req_priv_i,
  output logic         req_accept_o,
  output logic         req_valid_o,
  output logic [127:0] req_inst_o,
  output logic         req_error_o,
  output logic         req_page_fault_o,
  output logic         mem_rd_o,
  output logic [31:0]  mem_addr_o,
  input  logic         mem_accept_i,
  input  logic         mem_valid_i,
  input  logic         mem_error_i,
  input  logic [127:0] mem_data_i
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;

  typedef enum logic [1:0] {
    ST_FLUSH    = 2'd0,
    ST_IDLE     = 2'd1,
    ST_MEM_REQ  = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  state_t              state;
  logic [INDEX_W-1:0]  flush_cnt;
  logic                lookup_q;
  logic                flush_pending_q;
  logic [27:0]         line_q;          // pc_q[31:4]; byte offset is never used
  logic                mem_rd_q;
  logic [31:0]         mem_addr_q;

  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [127:0]        data_mem [LINES];
  logic [TAG_W-1:0]    tag_rd_q;
  logic [127:0]        data_rd_q;

  logic                flush_req;
  logic [INDEX_W-1:0]  req_idx;
  logic [INDEX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]    cur_tag;
  logic                hit;
  logic                accept;
  logic                accept_fire;
  logic                refill_done;
  logic                refill_wr;
  logic                unused_ok;

  assign flush_req   = req_flush_i | req_invalidate_i;
  assign req_idx     = req_pc_i[4 +: INDEX_W];
  assign cur_idx     = line_q[INDEX_W-1:0];
  assign cur_tag     = line_q[27:INDEX_W];
  assign hit         = valid_q[cur_idx] && (tag_rd_q == cur_tag);
  // A missing lookup blocks new requests so only one miss is ever in flight.
  assign accept      = (state == ST_IDLE) && !flush_req && !flush_pending_q &&
                       !(lookup_q && !hit);
  assign accept_fire = req_rd_i && accept;
  assign refill_done = (state == ST_MEM_WAIT) && mem_valid_i;
  assign refill_wr   = refill_done && !mem_error_i;

  assign req_accept_o     = accept;
  assign req_valid_o      = (lookup_q && hit) || refill_done;
  assign req_inst_o       = refill_done       ? mem_data_i :
                            (lookup_q && hit) ? data_rd_q  : '0;
  assign req_error_o      = refill_done && mem_error_i;
  assign req_page_fault_o = 1'b0;
  assign mem_rd_o         = mem_rd_q;
  assign mem_addr_o       = mem_addr_q;

  assign unused_ok = ^{req_priv_i, req_pc_i[3:0]};

  // Tag/data arrays: synchronous read on accept, write on a clean refill.
  // Reads and refill writes never coincide because requests are blocked
  // while a refill is outstanding.
  always_ff @(posedge clk_i) begin
    if (refill_wr) begin
      tag_mem[cur_idx]  <= cur_tag;
      data_mem[cur_idx] <= mem_data_i;
    end
    if (accept_fire) begin
      tag_rd_q  <= tag_mem[req_idx];
      data_rd_q <= data_mem[req_idx];
    end
  end

  // Valid bits: walked clear by FLUSH, set by an error-free refill.
  always_ff @(posedge clk_i) begin
    if (state == ST_FLUSH) begin
      valid_q[flush_cnt] <= 1'b0;
    end else if (refill_wr) begin
      valid_q[cur_idx] <= 1'b1;
    end
  end

  // Control FSM: flush walk, lookup tracking and the refill handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_FLUSH;
      flush_cnt       <= '0;
      lookup_q        <= 1'b0;
      flush_pending_q <= 1'b0;
      line_q          <= '0;
      mem_rd_q        <= 1'b0;
      mem_addr_q      <= '0;
    end else begin
      case (state)
        ST_FLUSH: begin
          lookup_q        <= 1'b0;
          flush_pending_q <= 1'b0;
          if (flush_req) begin
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + INDEX_W'(1);
            if (flush_cnt == '1) state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          lookup_q <= accept_fire;
          if (accept_fire) line_q <= req_pc_i[31:4];
          if (lookup_q) begin
            // A flush during a lookup waits until that lookup has resolved.
            if (flush_req) flush_pending_q <= 1'b1;
            if (!hit) begin
              state      <= ST_MEM_REQ;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= {line_q, 4'b0000};
            end
          end else if (flush_req || flush_pending_q) begin
            state           <= ST_FLUSH;
            flush_cnt       <= '0;
            flush_pending_q <= 1'b0;
          end
        end
        ST_MEM_REQ: begin
          if (flush_req) flush_pending_q <= 1'b1;
          if (mem_accept_i) begin
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            state      <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (flush_req) flush_pending_q <= 1'b1;
          if (mem_valid_i) state <= ST_IDLE;
        end
        default: state <= ST_FLUSH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_dm
//  Purpose  : Self-checking bench for icache_dm against a line-level model
//             (valid/tag per index plus a memory image keyed by line address).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_icache_dm;

  localparam int IW    = 6;
  localparam int LINES = 1 << IW;
  localparam int TAG_W = 28 - IW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_rd = 1'b0;
  logic         req_flush = 1'b0;
  logic         req_inval = 1'b0;
  logic [31:0]  req_pc = '0;
  logic [1:0]   req_priv = 2'd3;
  logic         req_accept, req_valid, req_error, req_pf;
  logic [127:0] req_inst;
  logic         mem_rd;
  logic [31:0]  mem_addr;
  logic         mem_accept = 1'b0;
  logic         mem_valid = 1'b0;
  logic         mem_error = 1'b0;
  logic [127:0] mem_data = '0;

  always #5 clk = ~clk;

  icache_dm #(.INDEX_W(IW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_rd_i         (req_rd),
    .req_flush_i      (req_flush),
    .req_invalidate_i (req_inval),
    .req_pc_i         (req_pc),
    .req_priv_i       (req_priv),
    .req_accept_o     (req_accept),
    .req_valid_o      (req_valid),
    .req_inst_o       (req_inst),
    .req_error_o      (req_error),
    .req_page_fault_o (req_pf),
    .mem_rd_o         (mem_rd),
    .mem_addr_o       (mem_addr),
    .mem_accept_i     (mem_accept),
    .mem_valid_i      (mem_valid),
    .mem_error_i      (mem_error),
    .mem_data_i       (mem_data)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: which line each index holds, and backing memory contents.
  bit               m_valid [LINES];
  logic [TAG_W-1:0] m_tag   [LINES];
  logic [127:0]     mem_img [bit [27:0]];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic model_flush();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic get_line(input bit [27:0] ln, output logic [127:0] d);
    if (!mem_img.exists(ln)) mem_img[ln] = {$urandom, $urandom, $urandom, $urandom};
    d = mem_img[ln];
  endtask

  // One complete read: request, lookup, and (on a model miss) the refill.
  task automatic read_line(input logic [31:0] pc, input int stall, input int lat,
                           input bit err, input bit flush_in_wait);
    int               idx;
    logic [TAG_W-1:0] tg;
    bit               hit;
    logic [127:0]     d;
    int               n;
    idx = int'(pc[4 +: IW]);
    tg  = pc[31:4+IW];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    get_line(pc[31:4], d);

    req_rd = 1'b1;
    req_pc = pc;
    #1;
    n = 0;
    while (!req_accept && n < 200) begin
      step();
      n++;
    end
    chk("accept", {127'd0, req_accept}, 128'd1);
    step();
    req_rd = 1'b0;
    chk("lookup_valid", {127'd0, req_valid}, {127'd0, hit});
    chk("lookup_memrd", {127'd0, mem_rd}, 128'd0);
    if (hit) begin
      chk("hit_data", req_inst, d);
      chk("hit_err", {127'd0, req_error}, 128'd0);
    end else begin
      step();
      for (int i = 0; i < stall; i++) begin
        chk("stall_memrd", {127'd0, mem_rd}, 128'd1);
        chk("stall_addr", {96'd0, mem_addr}, {96'd0, pc[31:4], 4'b0000});
        step();
      end
      chk("req_memrd", {127'd0, mem_rd}, 128'd1);
      chk("req_addr", {96'd0, mem_addr}, {96'd0, pc[31:4], 4'b0000});
      mem_accept = 1'b1;
      step();
      mem_accept = 1'b0;
      chk("wait_memrd", {127'd0, mem_rd}, 128'd0);
      if (flush_in_wait) begin
        req_flush = 1'b1;
        #1;
        chk("wait_flush_acc", {127'd0, req_accept}, 128'd0);
        step();
        req_flush = 1'b0;
      end
      for (int i = 0; i < lat; i++) begin
        chk("wait_valid", {127'd0, req_valid}, 128'd0);
        step();
      end
      mem_valid = 1'b1;
      mem_data  = d;
      mem_error = err;
      #1;
      chk("refill_valid", {127'd0, req_valid}, 128'd1);
      chk("refill_data", req_inst, d);
      chk("refill_err", {127'd0, req_error}, {127'd0, err});
      step();
      mem_valid = 1'b0;
      mem_error = 1'b0;
      mem_data  = '0;
      chk("post_valid", {127'd0, req_valid}, 128'd0);
      if (!err) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
      end
      if (flush_in_wait) begin
        for (int i = 0; i < 64; i++) begin
          chk("flush_block", {127'd0, req_accept}, 128'd0);
          step();
        end
        model_flush();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d123;
    logic [31:0]  pc;
    model_flush();
    mem_img[28'h0000123] = 128'hDEADBEEF_01234567_89ABCDEF_00112233;
    d123 = 128'hDEADBEEF_01234567_89ABCDEF_00112233;

    // Reset state, with a read already held pending.
    req_rd = 1'b1;
    req_pc = 32'h0000_1234;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_accept", {127'd0, req_accept}, 128'd0);
    chk("rst_valid", {127'd0, req_valid}, 128'd0);
    chk("rst_inst", req_inst, 128'd0);
    chk("rst_err", {127'd0, req_error}, 128'd0);
    chk("rst_pf", {127'd0, req_pf}, 128'd0);
    chk("rst_memrd", {127'd0, mem_rd}, 128'd0);
    chk("rst_addr", {96'd0, mem_addr}, 128'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) begin
      chk("init_flush_acc", {127'd0, req_accept}, 128'd0);
      step();
    end
    chk("first_accept", {127'd0, req_accept}, 128'd1);

    // Cold miss with a 3-cycle accept stall.
    read_line(32'h0000_1234, 3, 1, 1'b0, 1'b0);
    // Same line again: hit.
    read_line(32'h0000_1238, 0, 0, 1'b0, 1'b0);

    // Back-to-back hits on consecutive cycles.
    req_rd = 1'b1;
    req_pc = 32'h0000_1230;
    #1;
    chk("b2b_acc0", {127'd0, req_accept}, 128'd1);
    step();
    chk("b2b_valid0", {127'd0, req_valid}, 128'd1);
    chk("b2b_data0", req_inst, d123);
    req_pc = 32'h0000_123C;
    #1;
    chk("b2b_acc1", {127'd0, req_accept}, 128'd1);
    step();
    req_rd = 1'b0;
    chk("b2b_valid1", {127'd0, req_valid}, 128'd1);
    chk("b2b_data1", req_inst, d123);
    chk("b2b_memrd", {127'd0, mem_rd}, 128'd0);
    step();

    // Conflict misses on one index.
    read_line(32'h0000_0010, 0, 0, 1'b0, 1'b0);
    read_line(32'h0000_0410, 1, 2, 1'b0, 1'b0);
    read_line(32'h0000_0010, 2, 0, 1'b0, 1'b0);

    // Bus error: not allocated, so the repeat read refills again.
    read_line(32'h0000_2000, 0, 1, 1'b1, 1'b0);
    read_line(32'h0000_2000, 0, 0, 1'b0, 1'b0);
    read_line(32'h0000_2004, 0, 0, 1'b0, 1'b0);

    // Flush during MEM_WAIT: response still delivered, then a full flush.
    read_line(32'h0000_3000, 1, 2, 1'b0, 1'b1);
    read_line(32'h0000_3000, 0, 0, 1'b0, 1'b0);
    read_line(32'h0000_1234, 0, 0, 1'b0, 1'b0);

    // Randomised traffic over a small address pool, with idle flushes.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        req_rd = 1'b1;
        if ($urandom_range(0, 1) == 0) req_flush = 1'b1;
        else req_inval = 1'b1;
        #1;
        chk("idle_flush_acc", {127'd0, req_accept}, 128'd0);
        step();
        req_flush = 1'b0;
        req_inval = 1'b0;
        req_rd    = 1'b0;
        model_flush();
      end else begin
        pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
             32'($urandom_range(0, 15));
        read_line(pc, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
